// File: rtl/trail_unwinder.sv
// Assignment-trail stack with single push/pop/replace and a hardware unwind to the last decision.
// Latency: push/pop take effect at the next posedge; unwind streams its first beat the cycle after unwind_req.
// Backpressure: an unwind beat holds stable while out_ready is low, and an entry is popped only on out_valid && out_ready.
//
// Ports:
//   clock, reset         - system clock, synchronous active-high reset
//   push/var_in/val_in/type_in, pop - single trail operations (accepted only while idle)
//   unwind_req           - start streaming entries down to the most recent decision
//   top_var/top_val/top_type - current top entry (zero when the trail is empty)
//   out_valid/out_ready/out_var/out_val/out_type/out_last - unwind stream
//   busy, done, no_decision - unwind status (done is a one-cycle pulse)
//   empty, full, count, decision_level, overflow - trail status

module trail_unwinder #(
   parameter  int DEPTH    = 64,
   parameter  int VAR_BITS = 8,
   localparam int CNT_BITS = $clog2(DEPTH) + 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                push,
   input  logic [VAR_BITS-1:0] var_in,
   input  logic                val_in,
   input  logic                type_in,
   input  logic                pop,
   input  logic                unwind_req,
   output logic [VAR_BITS-1:0] top_var,
   output logic                top_val,
   output logic                top_type,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [VAR_BITS-1:0] out_var,
   output logic                out_val,
   output logic                out_type,
   output logic                out_last,
   output logic                busy,
   output logic                done,
   output logic                no_decision,
   output logic                empty,
   output logic                full,
   output logic [CNT_BITS-1:0] count,
   output logic [CNT_BITS-1:0] decision_level,
   output logic                overflow
);

   localparam int PTR_BITS = $clog2(DEPTH);

   // typ: 0 = decision, 1 = forced/implied
   typedef struct packed {
      logic [VAR_BITS-1:0] var_idx;
      logic                val;
      logic                typ;
   } entry_t;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_UNWIND = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   entry_t              r_mem [DEPTH];
   state_t              r_state;
   logic [CNT_BITS-1:0] r_count;
   logic [CNT_BITS-1:0] r_dlevel;
   logic                r_overflow;
   logic                r_no_dec;

   // ------------------------------------------------------------------
   // Combinational signals
   // ------------------------------------------------------------------
   state_t              w_state_nxt;
   logic                w_empty;
   logic                w_full;
   logic [PTR_BITS-1:0] w_top_idx;
   logic [PTR_BITS-1:0] w_push_idx;
   entry_t              w_top;
   entry_t              w_new;
   logic                w_do_push;
   logic                w_do_pop;
   logic                w_do_repl;
   logic                w_set_ovf;
   logic                w_nd_load;
   logic                w_nd_val;
   logic                w_wr_en;
   logic [PTR_BITS-1:0] w_wr_idx;
   logic                w_add_dec;
   logic                w_sub_dec;
   logic [CNT_BITS-1:0] w_count_nxt;
   logic [CNT_BITS-1:0] w_dlevel_nxt;
   logic                w_stream_vld;

   assign w_empty    = (r_count == '0);
   assign w_full     = (r_count == CNT_BITS'(DEPTH));
   // The top index wraps to DEPTH-1 when empty; w_top is masked in that case.
   assign w_top_idx  = PTR_BITS'(r_count - CNT_BITS'(1));
   // Only used when not full, so count fits in the pointer width.
   assign w_push_idx = PTR_BITS'(r_count);
   assign w_top      = w_empty ? '0 : r_mem[w_top_idx];
   assign w_new      = '{var_idx: var_in, val: val_in, typ: type_in};

   // ------------------------------------------------------------------
   // Next-state and operation decode
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_do_push   = 1'b0;
      w_do_pop    = 1'b0;
      w_do_repl   = 1'b0;
      w_set_ovf   = 1'b0;
      w_nd_load   = 1'b0;
      w_nd_val    = 1'b0;

      unique case (r_state)
         S_IDLE: begin
            // An unwind request swallows any push/pop issued alongside it.
            if (unwind_req) begin
               w_state_nxt = S_UNWIND;
            end else if (push && pop && !w_empty) begin
               w_do_repl = 1'b1;
            end else if (push) begin
               if (w_full) begin
                  w_set_ovf = 1'b1;
               end else begin
                  w_do_push = 1'b1;
               end
            end else if (pop && !w_empty) begin
               w_do_pop = 1'b1;
            end
         end

         S_UNWIND: begin
            if (w_empty) begin
               // Ran out of trail without meeting a decision.
               w_state_nxt = S_DONE;
               w_nd_load   = 1'b1;
               w_nd_val    = 1'b1;
            end else if (out_ready) begin
               w_do_pop = 1'b1;
               if (!w_top.typ) begin
                  w_state_nxt = S_DONE;
                  w_nd_load   = 1'b1;
                  w_nd_val    = 1'b0;
               end
            end
         end

         S_DONE: begin
            w_state_nxt = S_IDLE;
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Count and decision-level arithmetic
   // ------------------------------------------------------------------
   assign w_add_dec = (w_do_push || w_do_repl) && !type_in;
   assign w_sub_dec = (w_do_pop  || w_do_repl) && !w_top.typ;

   always_comb begin
      w_count_nxt = r_count;
      if (w_do_push) begin
         w_count_nxt = r_count + CNT_BITS'(1);
      end else if (w_do_pop) begin
         w_count_nxt = r_count - CNT_BITS'(1);
      end
   end

   assign w_dlevel_nxt = r_dlevel + CNT_BITS'(w_add_dec) - CNT_BITS'(w_sub_dec);

   // ------------------------------------------------------------------
   // Storage: a replace overwrites the top slot, a push writes above it.
   // ------------------------------------------------------------------
   assign w_wr_en  = !reset && (w_do_push || w_do_repl);
   assign w_wr_idx = w_do_repl ? w_top_idx : w_push_idx;

   always_ff @(posedge clock) begin
      if (w_wr_en) begin
         r_mem[w_wr_idx] <= w_new;
      end
   end

   // ------------------------------------------------------------------
   // Control registers
   // ------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_count    <= '0;
         r_dlevel   <= '0;
         r_overflow <= 1'b0;
         r_no_dec   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_count  <= w_count_nxt;
         r_dlevel <= w_dlevel_nxt;
         if (w_set_ovf) begin
            r_overflow <= 1'b1;
         end
         if (w_nd_load) begin
            r_no_dec <= w_nd_val;
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign w_stream_vld = (r_state == S_UNWIND) && !w_empty;

   assign top_var  = w_top.var_idx;
   assign top_val  = w_top.val;
   assign top_type = w_top.typ;

   assign out_valid = w_stream_vld;
   assign out_var   = w_stream_vld ? w_top.var_idx : '0;
   assign out_val   = w_stream_vld && w_top.val;
   assign out_type  = w_stream_vld && w_top.typ;
   assign out_last  = w_stream_vld && !w_top.typ;

   assign busy        = (r_state != S_IDLE);
   assign done        = (r_state == S_DONE);
   assign no_decision = (r_state == S_DONE) && r_no_dec;

   assign empty          = w_empty;
   assign full           = w_full;
   assign count          = r_count;
   assign decision_level = r_dlevel;
   assign overflow       = r_overflow;

endmodule

// File: tb/tb_trail_unwinder.sv
module tb_trail_unwinder;

   localparam int DEPTH = 4;
   localparam int VB    = 8;
   localparam int CB    = $clog2(DEPTH) + 1;

   logic          clock = 1'b0;
   logic          reset;
   logic          push;
   logic [VB-1:0] var_in;
   logic          val_in;
   logic          type_in;
   logic          pop;
   logic          unwind_req;
   logic [VB-1:0] top_var;
   logic          top_val;
   logic          top_type;
   logic          out_valid;
   logic          out_ready;
   logic [VB-1:0] out_var;
   logic          out_val;
   logic          out_type;
   logic          out_last;
   logic          busy;
   logic          done;
   logic          no_decision;
   logic          empty;
   logic          full;
   logic [CB-1:0] count;
   logic [CB-1:0] decision_level;
   logic          overflow;

   trail_unwinder #(.DEPTH(DEPTH), .VAR_BITS(VB)) dut (
      .clock(clock), .reset(reset), .push(push), .var_in(var_in), .val_in(val_in),
      .type_in(type_in), .pop(pop), .unwind_req(unwind_req), .top_var(top_var),
      .top_val(top_val), .top_type(top_type), .out_valid(out_valid), .out_ready(out_ready),
      .out_var(out_var), .out_val(out_val), .out_type(out_type), .out_last(out_last),
      .busy(busy), .done(done), .no_decision(no_decision), .empty(empty), .full(full),
      .count(count), .decision_level(decision_level), .overflow(overflow)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [VB-1:0] v;
      logic          val;
      logic          typ;
   } ent_t;

   typedef struct packed {
      logic [VB-1:0] v;
      logic          val;
      logic          typ;
      logic          last;
   } beat_t;

   int nerr = 0;
   int nchk = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model: the trail is a queue (back = top); mode 0 idle,
   // 1 unwinding, 2 reporting completion.
   // ------------------------------------------------------------------
   ent_t  q[$];
   int    m_mode  = 0;
   bit    m_ovf   = 0;
   bit    m_nd    = 0;
   bit    started = 0;
   beat_t beats[$];

   function automatic int model_dl();
      int d = 0;
      foreach (q[i]) if (!q[i].typ) d++;
      return d;
   endfunction

   always @(posedge clock) begin
      ent_t e;
      started = 1;
      if (reset) begin
         q.delete();
         m_mode = 0;
         m_ovf  = 0;
         m_nd   = 0;
      end else begin
         case (m_mode)
            0: begin
               if (unwind_req) m_mode = 1;
               else if (push && pop && q.size() > 0) q[q.size()-1] = '{var_in, val_in, type_in};
               else if (push) begin
                  if (q.size() == DEPTH) m_ovf = 1;
                  else q.push_back('{var_in, val_in, type_in});
               end else if (pop && q.size() > 0) void'(q.pop_back());
            end
            1: begin
               if (q.size() == 0) begin
                  m_mode = 2;
                  m_nd   = 1;
               end else if (out_ready) begin
                  e = q.pop_back();
                  if (!e.typ) begin
                     m_mode = 2;
                     m_nd   = 0;
                  end
               end
            end
            default: m_mode = 0;
         endcase
      end
   end

   always @(negedge clock) begin
      ent_t t;
      bit   sv;
      if (started) begin
         t  = (q.size() > 0) ? q[q.size()-1] : '0;
         sv = (m_mode == 1) && (q.size() > 0);
         check("count", count, q.size());
         check("decision_level", decision_level, model_dl());
         check("empty", empty, q.size() == 0);
         check("full", full, q.size() == DEPTH);
         check("overflow", overflow, m_ovf);
         check("top_var", top_var, t.v);
         check("top_val", top_val, t.val);
         check("top_type", top_type, t.typ);
         check("busy", busy, m_mode != 0);
         check("done", done, m_mode == 2);
         check("no_decision", no_decision, (m_mode == 2) && m_nd);
         check("out_valid", out_valid, sv);
         check("out_var", out_var, sv ? t.v : 8'd0);
         check("out_val", out_val, sv && t.val);
         check("out_type", out_type, sv && t.typ);
         check("out_last", out_last, sv && !t.typ);
         if (out_valid && out_ready && !reset)
            beats.push_back('{out_var, out_val, out_type, out_last});
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_push(input logic [VB-1:0] v, input logic val, input logic typ);
      push = 1'b1; var_in = v; val_in = val; type_in = typ;
      step();
      push = 1'b0;
   endtask

   task automatic do_pop();
      pop = 1'b1;
      step();
      pop = 1'b0;
   endtask

   // Call right after the unwind_req cycle; cyc counts cycles since the request.
   task automatic wait_done(output int cyc);
      cyc = 1;
      while (!done && cyc < 40) begin
         step();
         cyc++;
      end
      if (!done) begin
         nchk++;
         nerr++;
         $display("FAIL done_timeout: done not seen within %0d cycles", cyc);
      end
   endtask

   task automatic start_unwind();
      beats.delete();
      unwind_req = 1'b1;
      out_ready  = 1'b1;
      step();
      unwind_req = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int cyc;
      reset = 1'b1; push = 1'b0; pop = 1'b0; unwind_req = 1'b0; out_ready = 1'b0;
      var_in = '0; val_in = 1'b0; type_in = 1'b0;
      step();
      step();
      reset = 1'b0;
      check("rst_empty", empty, 1);
      check("rst_count", count, 0);
      check("rst_busy", busy, 0);

      // Build a trail with one decision in the middle.
      do_push(8'd5, 1'b1, 1'b1);
      do_push(8'd9, 1'b0, 1'b1);
      do_push(8'd3, 1'b1, 1'b0);
      do_push(8'd7, 1'b0, 1'b1);
      check("p4_count", count, 4);
      check("p4_dl", decision_level, 1);
      check("p4_top", {top_var, top_val, top_type}, {8'd7, 1'b0, 1'b1});
      check("p4_model_cnt", q.size(), 4);

      // Unwind to the decision (3,1,0).
      start_unwind();
      wait_done(cyc);
      check("u1_cyc", cyc, 3);
      check("u1_nbeats", beats.size(), 2);
      if (beats.size() >= 2) begin
         check("u1_b0", beats[0], {8'd7, 1'b0, 1'b1, 1'b0});
         check("u1_b1", beats[1], {8'd3, 1'b1, 1'b0, 1'b1});
      end
      check("u1_nd", no_decision, 0);
      check("u1_count", count, 2);
      check("u1_dl", decision_level, 0);
      check("u1_top", {top_var, top_val, top_type}, {8'd9, 1'b0, 1'b1});
      step();

      // Only forced entries remain: stream both, then report no decision.
      start_unwind();
      wait_done(cyc);
      check("u2_cyc", cyc, 4);
      check("u2_nbeats", beats.size(), 2);
      if (beats.size() >= 2) begin
         check("u2_b0_last", beats[0].last, 0);
         check("u2_b1_last", beats[1].last, 0);
      end
      check("u2_nd", no_decision, 1);
      check("u2_empty", empty, 1);
      step();

      // Unwind on an empty trail.
      start_unwind();
      wait_done(cyc);
      check("u3_cyc", cyc, 2);
      check("u3_nbeats", beats.size(), 0);
      check("u3_nd", no_decision, 1);
      step();

      // Backpressure: ready pattern 1,0,0,1 across a 3-entry unwind.
      do_push(8'd1, 1'b1, 1'b0);
      do_push(8'd2, 1'b0, 1'b1);
      do_push(8'd4, 1'b1, 1'b1);
      start_unwind();
      step();
      out_ready = 1'b0;
      check("bp_hold1", {out_valid, out_var}, {1'b1, 8'd2});
      step();
      check("bp_hold2", {out_valid, out_var}, {1'b1, 8'd2});
      check("bp_count", count, 2);
      out_ready = 1'b1;
      wait_done(cyc);
      check("bp_nbeats", beats.size(), 3);
      if (beats.size() >= 3) check("bp_b2", beats[2], {8'd1, 1'b1, 1'b0, 1'b1});
      check("bp_nd", no_decision, 0);
      check("bp_count_end", count, 0);
      step();

      // Fill, overflow, replace-while-full, drain, pop on empty.
      do_push(8'd21, 1'b1, 1'b1);
      do_push(8'd22, 1'b0, 1'b0);
      do_push(8'd23, 1'b1, 1'b1);
      check("f3_full", full, 0);
      do_push(8'd24, 1'b0, 1'b1);
      check("f4_full", full, 1);
      check("f4_ovf", overflow, 0);
      do_push(8'd25, 1'b1, 1'b0);
      check("f5_ovf", overflow, 1);
      check("f5_count", count, 4);
      check("f5_top", top_var, 8'd24);
      check("f5_dl", decision_level, 1);
      pop = 1'b1;
      do_push(8'd33, 1'b1, 1'b0);
      check("rep_top", {top_var, top_val, top_type}, {8'd33, 1'b1, 1'b0});
      check("rep_count", count, 4);
      check("rep_dl", decision_level, 2);
      repeat (4) do_pop();
      check("drain_count", count, 0);
      do_pop();
      check("pop_empty_count", count, 0);
      check("pop_empty_dl", decision_level, 0);
      check("pop_empty_ovf", overflow, 1);

      // Reset mid-unwind after one beat.
      do_push(8'd10, 1'b0, 1'b0);
      do_push(8'd11, 1'b1, 1'b1);
      do_push(8'd12, 1'b0, 1'b1);
      start_unwind();
      step();
      check("mr_count_pre", count, 2);
      check("mr_busy_pre", busy, 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("mr_count", count, 0);
      check("mr_busy", busy, 0);
      check("mr_ovf", overflow, 0);
      for (int i = 0; i < 3; i++) begin
         check("mr_no_done", done, 0);
         step();
      end

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         reset      = ($urandom_range(0, 299) == 0);
         push       = ($urandom_range(0, 99) < 45);
         pop        = ($urandom_range(0, 99) < 30);
         unwind_req = ($urandom_range(0, 99) < 8);
         out_ready  = ($urandom_range(0, 99) < 70);
         var_in     = VB'($urandom);
         val_in     = 1'($urandom);
         type_in    = ($urandom_range(0, 99) < 35) ? 1'b0 : 1'b1;
         step();
      end
      reset = 1'b0; push = 1'b0; pop = 1'b0; unwind_req = 1'b0;
      step();
      step();

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
